// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback result select, 32 x XLEN integer register file
// and committed-write counter for the W stage of the 5-stage RISC-V core.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   RegWriteW           write enable from MEM/WB
//   ResultSrcW          00 ALUResultW, 01 ReadDataW, 10 PCplus4W, 11 zero
//   rdW                 destination register index
//   ALUResultW          ALU result
//   ReadDataW           load data
//   PCplus4W            jal/jalr return address
//   rs1D, rs2D          decode read indices
//   RD1D, RD2D          combinational read data (x0 reads as 0)
//   ResultW             combinational writeback value, to forwarding muxes
//   WbCountW            number of committed register writes (wraps)
//
// Build option:
//   REGFILE_BYPASS_EN   when defined, a read of the register being committed
//                       this cycle returns ResultW (write-through); otherwise
//                       the old stored value is returned until the edge.
module writeback_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCplus4W,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] WbCountW
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] wb_count_q;
  logic [XLEN-1:0] wb_count_d;
  logic            commit_c;

  // Writeback result select
  always_comb begin
    ResultW = '0;
    unique case (ResultSrcW)
      2'b00:   ResultW = ALUResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCplus4W;
      default: ResultW = '0;
    endcase
  end

  // A commit is a real register write: x0 targets and reset cycles are dropped
  assign commit_c = RegWriteW && (rdW != 5'd0) && !reset;

  // Commit counter next state
  always_comb begin
    wb_count_d = wb_count_q;
    if (commit_c) begin
      wb_count_d = wb_count_q + XLEN'(1);
    end
  end

  // Register file and counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      if (commit_c) begin
        regs_q[rdW] <= ResultW;
      end
      wb_count_q <= wb_count_d;
    end
  end

  assign WbCountW = wb_count_q;

  // Read ports; x0 is forced to zero so it never depends on stored state
  always_comb begin
    RD1D = regs_q[rs1D];
    RD2D = regs_q[rs2D];
`ifdef REGFILE_BYPASS_EN
    if (commit_c && (rs1D == rdW)) begin
      RD1D = ResultW;
    end
    if (commit_c && (rs2D == rdW)) begin
      RD2D = ResultW;
    end
`endif
    if (rs1D == 5'd0) begin
      RD1D = '0;
    end
    if (rs2D == 5'd0) begin
      RD2D = '0;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed cases plus randomized
// traffic compared against an array-based reference model.
module tb_writeback_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  rdW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCplus4W;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ResultW;
  logic [31:0] WbCountW;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m [32];
  logic [31:0] cnt_m;

  writeback_regfile #(.XLEN(32), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .rdW        (rdW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCplus4W   (PCplus4W),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ResultW    (ResultW),
    .WbCountW   (WbCountW)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] s, input logic [31:0] a,
                                             input logic [31:0] d, input logic [31:0] p);
    case (s)
      2'd0:    return a;
      2'd1:    return d;
      2'd2:    return p;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (BYPASS && !reset && RegWriteW && rdW != 5'd0 && idx == rdW)
      return ref_result(ResultSrcW, ALUResultW, ReadDataW, PCplus4W);
    return m[idx];
  endfunction

  // One clock cycle: drive, check mid-cycle, then advance model at the edge
  task automatic cycle(input logic rst, input logic we, input logic [1:0] src,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] dat,
                       input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
    reset = rst; RegWriteW = we; ResultSrcW = src; rdW = rd;
    ALUResultW = alu; ReadDataW = dat; PCplus4W = pc; rs1D = r1; rs2D = r2;
    @(negedge clk);
    check_eq("result", ResultW, ref_result(src, alu, dat, pc));
    check_eq("rd1", RD1D, ref_read(r1));
    check_eq("rd2", RD2D, ref_read(r2));
    check_eq("count", WbCountW, cnt_m);
    @(posedge clk);
    if (rst) begin
      foreach (m[i]) m[i] = 32'h0;
      cnt_m = 32'h0;
    end else if (we && rd != 5'd0) begin
      m[rd] = ref_result(src, alu, dat, pc);
      cnt_m = cnt_m + 32'd1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, r1, r2);
  endtask

  logic [31:0] mux_exp [4];
  int          kinds [15];

  initial begin
    mux_exp[0] = 32'h11; mux_exp[1] = 32'h22; mux_exp[2] = 32'h33; mux_exp[3] = 32'h0;

    // Power-up reset
    reset = 1'b1; RegWriteW = 1'b0; ResultSrcW = 2'd0; rdW = 5'd0;
    ALUResultW = '0; ReadDataW = '0; PCplus4W = '0; rs1D = 5'd0; rs2D = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    foreach (m[i]) m[i] = 32'h0;
    cnt_m = 32'h0;
    reset = 1'b0;
    check_eq("por_cnt", WbCountW, 32'h0);
    rs1D = 5'd9; rs2D = 5'd31;
    #1;
    check_eq("por_rd1", RD1D, 32'h0);
    check_eq("por_rd2", RD2D, 32'h0);

    // Reset clears a written register and the counter
    cycle(1'b0, 1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    cycle(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
    cycle(1'b1, 1'b1, 2'd0, 5'd6, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd6);
    rs1D = 5'd5; rs2D = 5'd6; reset = 1'b0; RegWriteW = 1'b0;
    #1;
    check_eq("rst_x5", RD1D, 32'h0);
    check_eq("rst_x6_lost", RD2D, 32'h0);
    check_eq("rst_cnt", WbCountW, 32'h0);

    // Result mux and commit into x3
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0, 1'b1, 2'(s), 5'd3, 32'h11, 32'h22, 32'h33, 5'd3, 5'd3);
      check_eq("mux_x3", RD1D, mux_exp[s]);
    end

    // x0 protection
    cycle(1'b0, 1'b1, 2'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    check_eq("x0_rd", RD1D, 32'h0);
    check_eq("x0_cnt", WbCountW, 32'd4);

    // Same-cycle read of the register being written
    cycle(1'b0, 1'b1, 2'd0, 5'd7, 32'h1, 32'h0, 32'h0, 5'd0, 5'd0);
    RegWriteW = 1'b1; ResultSrcW = 2'd0; rdW = 5'd7; ALUResultW = 32'hA5A5A5A5;
    rs1D = 5'd7; rs2D = 5'd7;
    #1;
    check_eq("same_rd1", RD1D, BYPASS ? 32'hA5A5A5A5 : 32'h1);
    check_eq("same_rd2", RD2D, BYPASS ? 32'hA5A5A5A5 : 32'h1);
    cycle(1'b0, 1'b1, 2'd0, 5'd7, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    check_eq("after_rd1", RD1D, 32'hA5A5A5A5);

    // Counter: 10 commits, 3 disabled cycles, 2 x0 writes in shuffled order
    cycle(1'b1, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 15; i++) kinds[i] = (i < 10) ? 0 : ((i < 13) ? 1 : 2);
    for (int i = 14; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = kinds[i]; kinds[i] = kinds[j]; kinds[j] = t;
    end
    for (int i = 0; i < 15; i++) begin
      logic [4:0] rd;
      rd = (kinds[i] == 2) ? 5'd0 : 5'($urandom_range(31, 1));
      cycle(1'b0, kinds[i] != 1, 2'($urandom_range(3, 0)), rd, $urandom, $urandom,
            $urandom, 5'($urandom), rd);
    end
    check_eq("cnt10", WbCountW, 32'd10);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      logic [4:0] r1;
      logic [4:0] r2;
      rd = 5'($urandom);
      r1 = ($urandom_range(3, 0) == 0) ? rd : 5'($urandom);
      r2 = ($urandom_range(3, 0) == 0) ? rd : 5'($urandom);
      cycle($urandom_range(24, 0) == 0, $urandom_range(3, 0) != 0, 2'($urandom), rd,
            $urandom, $urandom, $urandom, r1, r2);
    end

    // Counter wrap from all-ones
    force dut.wb_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_q;
    cnt_m = 32'hFFFFFFFF;
    cycle(1'b0, 1'b1, 2'd2, 5'd12, 32'h0, 32'h0, 32'h40, 5'd12, 5'd0);
    check_eq("wrap_cnt", WbCountW, 32'h0);
    idle(5'd12, 5'd0);
    check_eq("wrap_x12", RD1D, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
